// File: rtl/wordle_pkg.sv
// Shared definitions for the Wordle board controller and its renderer.
// Holds the grid geometry, key/tile/FSM/game enums, letter code constants
// and a small helper to pick one letter out of a packed word.
package wordle_pkg;

  localparam int unsigned ROWS  = 6;
  localparam int unsigned COLS  = 5;
  localparam int unsigned LTR_W = 5;

  typedef enum logic [1:0] {
    KeyLetter    = 2'd0,
    KeyBackspace = 2'd1,
    KeyEnter     = 2'd2,
    KeyReserved  = 2'd3
  } key_type_e;

  // Renderer maps these straight to tile colours.
  typedef enum logic [1:0] {
    TilePending = 2'd0,
    TileAbsent  = 2'd1,
    TilePresent = 2'd2,
    TileCorrect = 2'd3
  } tile_status_e;

  typedef enum logic [1:0] {
    StEdit   = 2'd0,
    StScore  = 2'd1,
    StCommit = 2'd2,
    StDone   = 2'd3
  } board_state_e;

  typedef enum logic [1:0] {
    GamePlaying = 2'd0,
    GameWon     = 2'd1,
    GameLost    = 2'd2
  } game_state_e;

  localparam logic [LTR_W-1:0] LTR_A = 5'd0,  LTR_B = 5'd1,  LTR_C = 5'd2,  LTR_D = 5'd3;
  localparam logic [LTR_W-1:0] LTR_E = 5'd4,  LTR_F = 5'd5,  LTR_G = 5'd6,  LTR_H = 5'd7;
  localparam logic [LTR_W-1:0] LTR_I = 5'd8,  LTR_J = 5'd9,  LTR_K = 5'd10, LTR_L = 5'd11;
  localparam logic [LTR_W-1:0] LTR_M = 5'd12, LTR_N = 5'd13, LTR_O = 5'd14, LTR_P = 5'd15;
  localparam logic [LTR_W-1:0] LTR_Q = 5'd16, LTR_R = 5'd17, LTR_S = 5'd18, LTR_T = 5'd19;
  localparam logic [LTR_W-1:0] LTR_U = 5'd20, LTR_V = 5'd21, LTR_W_ = 5'd22, LTR_X = 5'd23;
  localparam logic [LTR_W-1:0] LTR_Y = 5'd24, LTR_Z = 5'd25;

  // Letter idx of a packed word; letter 0 sits in the low bits.
  function automatic logic [LTR_W-1:0] word_letter(input logic [COLS*LTR_W-1:0] word,
                                                   input logic [2:0] idx);
    return word[idx*LTR_W +: LTR_W];
  endfunction

endpackage

// File: rtl/wordle_scorer.sv
// Two-pass Wordle scorer.
// Pass G (COLS cycles) marks exact matches CORRECT and reserves those target
// letters; pass Y (COLS cycles) gives each remaining guess letter the lowest
// unreserved matching target letter, marking it PRESENT.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : abandon any pass in progress
//   start     : latch guess/target and begin pass G
//   guess     : packed guess word, letter 0 in [4:0]
//   target    : packed target word, letter 0 in [4:0]
//   done      : high in the cycle the final step is taken; status is complete
//               from the following cycle
//   status    : 2 bits per letter (tile_status_e), letter 0 in [1:0]
module wordle_scorer
  import wordle_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  start,
  input  logic [COLS*LTR_W-1:0] guess,
  input  logic [COLS*LTR_W-1:0] target,
  output logic                  done,
  output logic [2*COLS-1:0]     status
);

  typedef enum logic [1:0] {PhIdle, PhGreen, PhYellow} phase_e;

  localparam logic [2:0] LastIdx = 3'(COLS - 1);

  phase_e                phase_q, phase_d;
  logic [2:0]            idx_q, idx_d;
  logic [COLS-1:0]       used_q, used_d;
  logic [2*COLS-1:0]     scratch_q, scratch_d;
  logic [COLS*LTR_W-1:0] guess_q, target_q;

  logic [LTR_W-1:0] cur_g, cur_t;
  logic             hit_found;
  logic [2:0]       hit_j;

  always_comb begin
    cur_g = word_letter(guess_q, idx_q);
    cur_t = word_letter(target_q, idx_q);
    // Descending scan so the lowest free match wins.
    hit_found = 1'b0;
    hit_j     = '0;
    for (int j = int'(COLS) - 1; j >= 0; j--) begin
      if (!used_q[j] && (target_q[j*LTR_W +: LTR_W] == cur_g)) begin
        hit_found = 1'b1;
        hit_j     = 3'(j);
      end
    end
  end

  always_comb begin
    phase_d   = phase_q;
    idx_d     = idx_q;
    used_d    = used_q;
    scratch_d = scratch_q;
    done      = 1'b0;

    unique case (phase_q)
      PhIdle: ;
      PhGreen: begin
        if (cur_g == cur_t) begin
          scratch_d[idx_q*2 +: 2] = TileCorrect;
          used_d[idx_q]           = 1'b1;
        end else begin
          scratch_d[idx_q*2 +: 2] = TileAbsent;
        end
        if (idx_q == LastIdx) begin
          phase_d = PhYellow;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      PhYellow: begin
        if ((scratch_q[idx_q*2 +: 2] != TileCorrect) && hit_found) begin
          scratch_d[idx_q*2 +: 2] = TilePresent;
          used_d[hit_j]           = 1'b1;
        end
        if (idx_q == LastIdx) begin
          phase_d = PhIdle;
          idx_d   = '0;
          done    = 1'b1;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: phase_d = PhIdle;
    endcase

    if (start) begin
      phase_d = PhGreen;
      idx_d   = '0;
      used_d  = '0;
    end
    if (clear) begin
      phase_d = PhIdle;
      idx_d   = '0;
      used_d  = '0;
      done    = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q   <= PhIdle;
      idx_q     <= '0;
      used_q    <= '0;
      scratch_q <= '0;
      guess_q   <= '0;
      target_q  <= '0;
    end else begin
      phase_q   <= phase_d;
      idx_q     <= idx_d;
      used_q    <= used_d;
      scratch_q <= scratch_d;
      if (start) begin
        guess_q  <= guess;
        target_q <= target;
      end
    end
  end

  assign status = scratch_q;

endmodule

// File: rtl/wordle_board_ctrl.sv
// Wordle game-board controller: 6x5 grid storage, keystroke FSM, row commit
// and a registered random-access read port for the VGA renderer.
// Ports:
//   dclk, clr         : pixel clock, asynchronous active-high reset
//   new_game          : pulse; clear the board and latch target_word
//   target_word       : five letter codes, letter 0 in [4:0]
//   key_valid/type/code, key_ready : keystroke handshake
//   rd_row, rd_col    : renderer cell index
//   rd_letter/filled/status : cell contents, one cycle after the index
//   cur_row, cur_col  : active row and next free column
//   game_state        : PLAYING / WON / LOST
//   busy              : scoring or commit in progress
module wordle_board_ctrl
  import wordle_pkg::*;
(
  input  logic                  dclk,
  input  logic                  clr,
  input  logic                  new_game,
  input  logic [COLS*LTR_W-1:0] target_word,
  input  logic                  key_valid,
  input  logic [1:0]            key_type,
  input  logic [LTR_W-1:0]      key_code,
  output logic                  key_ready,
  input  logic [2:0]            rd_row,
  input  logic [2:0]            rd_col,
  output logic [LTR_W-1:0]      rd_letter,
  output logic                  rd_filled,
  output logic [1:0]            rd_status,
  output logic [2:0]            cur_row,
  output logic [2:0]            cur_col,
  output logic [1:0]            game_state,
  output logic                  busy
);

  localparam logic [2:0] LastRow = 3'(ROWS - 1);
  localparam logic [2:0] FullCol = 3'(COLS);

  board_state_e state_q, state_d;

  logic [LTR_W-1:0] letter_q [ROWS][COLS];
  logic             filled_q [ROWS][COLS];
  logic [1:0]       status_q [ROWS][COLS];

  logic [COLS*LTR_W-1:0] target_q;
  logic [COLS*LTR_W-1:0] guess;
  logic [2:0]            row_q, col_q;
  game_state_e           game_q;

  logic              key_acc, do_letter, do_bksp, do_enter, do_commit;
  logic              sc_done, all_correct;
  logic [2*COLS-1:0] sc_status;

  // Key decode; every accepted key is consumed even when it has no effect.
  always_comb begin
    key_acc   = key_valid && key_ready;
    do_letter = key_acc && (key_type == KeyLetter) && (col_q < FullCol) && (key_code <= LTR_Z);
    do_bksp   = key_acc && (key_type == KeyBackspace) && (col_q != 3'd0);
    do_enter  = key_acc && (key_type == KeyEnter) && (col_q == FullCol);
    do_commit = (state_q == StCommit) && !new_game;
  end

  always_comb begin
    guess = '0;
    for (int c = 0; c < int'(COLS); c++) begin
      guess[c*LTR_W +: LTR_W] = letter_q[row_q][c];
    end
  end

  always_comb begin
    all_correct = 1'b1;
    for (int c = 0; c < int'(COLS); c++) begin
      if (sc_status[c*2 +: 2] != TileCorrect) all_correct = 1'b0;
    end
  end

  wordle_scorer u_scorer (
    .clk    (dclk),
    .rst    (clr),
    .clear  (new_game),
    .start  (do_enter),
    .guess  (guess),
    .target (target_q),
    .done   (sc_done),
    .status (sc_status)
  );

  // FSM state register
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q <= StEdit;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEdit:   if (do_enter) state_d = StScore;
      StScore:  if (sc_done) state_d = StCommit;
      StCommit: state_d = (all_correct || (row_q == LastRow)) ? StDone : StEdit;
      StDone:   ;
      default:  state_d = StEdit;
    endcase
    if (new_game) state_d = StEdit;
  end

  // FSM outputs
  always_comb begin
    key_ready = (state_q == StEdit) && !new_game;
    busy      = (state_q == StScore) || (state_q == StCommit);
  end

  // Grid, cursor, target and game result
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          letter_q[r][c] <= '0;
          filled_q[r][c] <= 1'b0;
          status_q[r][c] <= TilePending;
        end
      end
      target_q <= '0;
      row_q    <= '0;
      col_q    <= '0;
      game_q   <= GamePlaying;
    end else if (new_game) begin
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          letter_q[r][c] <= '0;
          filled_q[r][c] <= 1'b0;
          status_q[r][c] <= TilePending;
        end
      end
      target_q <= target_word;
      row_q    <= '0;
      col_q    <= '0;
      game_q   <= GamePlaying;
    end else begin
      if (do_letter) begin
        letter_q[row_q][col_q] <= key_code;
        filled_q[row_q][col_q] <= 1'b1;
        col_q                  <= col_q + 3'd1;
      end
      if (do_bksp) begin
        letter_q[row_q][col_q - 3'd1] <= '0;
        filled_q[row_q][col_q - 3'd1] <= 1'b0;
        col_q                         <= col_q - 3'd1;
      end
      // Whole row lands on one edge so the renderer never shows a partial score.
      if (do_commit) begin
        for (int c = 0; c < int'(COLS); c++) begin
          status_q[row_q][c] <= sc_status[c*2 +: 2];
        end
        if (all_correct) begin
          game_q <= GameWon;
        end else if (row_q == LastRow) begin
          game_q <= GameLost;
        end else begin
          row_q <= row_q + 3'd1;
          col_q <= '0;
        end
      end
    end
  end

  // Registered read port
  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      rd_letter <= '0;
      rd_filled <= 1'b0;
      rd_status <= TilePending;
    end else if ((rd_row < 3'(ROWS)) && (rd_col < 3'(COLS))) begin
      rd_letter <= letter_q[rd_row][rd_col];
      rd_filled <= filled_q[rd_row][rd_col];
      rd_status <= status_q[rd_row][rd_col];
    end else begin
      rd_letter <= '0;
      rd_filled <= 1'b0;
      rd_status <= TilePending;
    end
  end

  assign cur_row    = row_q;
  assign cur_col    = col_q;
  assign game_state = game_q;

endmodule

// File: tb/tb_wordle_board_ctrl.sv
// Scoreboard bench for wordle_board_ctrl: stimulus pushes expectations from a
// behavioural Wordle model; a monitor pops and compares on read results,
// state snapshots and the end of each scoring busy window.
module tb_wordle_board_ctrl;
  import wordle_pkg::*;

  logic        dclk = 1'b0;
  logic        clr = 1'b1;
  logic        new_game = 1'b0;
  logic [24:0] target_word = '0;
  logic        key_valid = 1'b0;
  logic [1:0]  key_type = 2'd0;
  logic [4:0]  key_code = 5'd0;
  logic        key_ready;
  logic [2:0]  rd_row = 3'd0, rd_col = 3'd0;
  logic [4:0]  rd_letter;
  logic        rd_filled;
  logic [1:0]  rd_status;
  logic [2:0]  cur_row, cur_col;
  logic [1:0]  game_state;
  logic        busy;

  always #20 dclk = ~dclk;

  wordle_board_ctrl dut (
    .dclk        (dclk),
    .clr         (clr),
    .new_game    (new_game),
    .target_word (target_word),
    .key_valid   (key_valid),
    .key_type    (key_type),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .rd_row      (rd_row),
    .rd_col      (rd_col),
    .rd_letter   (rd_letter),
    .rd_filled   (rd_filled),
    .rd_status   (rd_status),
    .cur_row     (cur_row),
    .cur_col     (cur_col),
    .game_state  (game_state),
    .busy        (busy)
  );

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {string name; logic [4:0] letter; logic filled; logic [1:0] status;} rd_exp_t;
  typedef struct {string name; int row; int col; int gs; int kr;} snap_exp_t;
  typedef struct {string name; int cycles; int row; int col; int gs; int kr;} cm_exp_t;

  rd_exp_t   rd_q[$];
  snap_exp_t sn_q[$];
  cm_exp_t   cm_q[$];

  logic rd_issue = 1'b0, rd_cap = 1'b0, snap_issue = 1'b0;

  // Reference model of the board
  logic [4:0] m_letter[6][5];
  logic       m_filled[6][5];
  logic [1:0] m_status[6][5];
  logic [4:0] m_tgt[5];
  int m_row = 0, m_col = 0, m_gs = 0;

  task automatic check(input string name, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [24:0] w5(input string s);
    logic [24:0] w = '0;
    for (int i = 0; i < 5; i++) w[i*5 +: 5] = 5'(s[i] - 8'd65);
    return w;
  endfunction

  // Standard Wordle scoring by letter counts
  function automatic void model_score(input int r);
    int cnt[26];
    for (int k = 0; k < 26; k++) cnt[k] = 0;
    for (int i = 0; i < 5; i++)
      if (m_letter[r][i] != m_tgt[i]) cnt[m_tgt[i]]++;
    for (int i = 0; i < 5; i++) begin
      if (m_letter[r][i] == m_tgt[i]) m_status[r][i] = 2'd3;
      else if (cnt[m_letter[r][i]] > 0) begin
        m_status[r][i] = 2'd2;
        cnt[m_letter[r][i]]--;
      end else m_status[r][i] = 2'd1;
    end
  endfunction

  function automatic void model_commit();
    cm_exp_t e;
    bit win = 1'b1;
    model_score(m_row);
    for (int i = 0; i < 5; i++) if (m_status[m_row][i] != 2'd3) win = 1'b0;
    if (win) m_gs = 1;
    else if (m_row == 5) m_gs = 2;
    else begin
      m_row++;
      m_col = 0;
    end
    e.name = "commit"; e.cycles = 11; e.row = m_row; e.col = m_col; e.gs = m_gs;
    e.kr = (m_gs == 0) ? 1 : 0;
    cm_q.push_back(e);
  endfunction

  // Returns 1 when the key starts a scoring pass
  function automatic bit model_key(input logic [1:0] t, input logic [4:0] c);
    if (m_gs != 0) return 1'b0;
    case (t)
      2'd0: if (m_col < 5 && c <= 5'd25) begin
        m_letter[m_row][m_col] = c;
        m_filled[m_row][m_col] = 1'b1;
        m_col++;
      end
      2'd1: if (m_col > 0) begin
        m_col--;
        m_letter[m_row][m_col] = 5'd0;
        m_filled[m_row][m_col] = 1'b0;
      end
      2'd2: if (m_col == 5) begin
        model_commit();
        return 1'b1;
      end
      default: ;
    endcase
    return 1'b0;
  endfunction

  function automatic void model_clear(input logic [24:0] w);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 5; c++) begin
        m_letter[r][c] = 5'd0;
        m_filled[r][c] = 1'b0;
        m_status[r][c] = 2'd0;
      end
    for (int i = 0; i < 5; i++) m_tgt[i] = w[i*5 +: 5];
    m_row = 0; m_col = 0; m_gs = 0;
  endfunction

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic do_read(input int r, input int c, input string nm);
    rd_exp_t e;
    e.name = nm;
    if (r < 6 && c < 5) begin
      e.letter = m_letter[r][c]; e.filled = m_filled[r][c]; e.status = m_status[r][c];
    end else begin
      e.letter = 5'd0; e.filled = 1'b0; e.status = 2'd0;
    end
    rd_q.push_back(e);
    rd_row = 3'(r); rd_col = 3'(c); rd_issue = 1'b1;
    tick();
    rd_issue = 1'b0;
  endtask

  task automatic read_row(input int r);
    for (int c = 0; c < 5; c++) do_read(r, c, $sformatf("cell_r%0d_c%0d", r, c));
  endtask

  task automatic snap(input string nm);
    snap_exp_t e;
    e.name = nm; e.row = m_row; e.col = m_col; e.gs = m_gs; e.kr = (m_gs == 0) ? 1 : 0;
    sn_q.push_back(e);
    snap_issue = 1'b1;
    tick();
    snap_issue = 1'b0;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 30 && busy; k++) tick();
    check("busy_timeout", int'(busy), 0);
  endtask

  task automatic send_key(input logic [1:0] t, input logic [4:0] c);
    bit ent;
    int r0;
    r0 = m_row;
    ent = model_key(t, c);
    key_valid = 1'b1; key_type = t; key_code = c;
    tick();
    key_valid = 1'b0; key_type = 2'd0; key_code = 5'd0;
    if (ent) begin
      wait_idle();
      read_row(r0);
    end
  endtask

  task automatic type_word(input logic [24:0] w);
    for (int i = 0; i < 5; i++) send_key(KeyLetter, w[i*5 +: 5]);
  endtask

  task automatic start_game(input logic [24:0] w);
    model_clear(w);
    target_word = w;
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
  endtask

  // Capture which cycles carried a read request into the registered port
  initial forever begin
    @(posedge dclk);
    rd_cap = rd_issue;
  end

  // Monitor
  initial begin
    rd_exp_t   re;
    snap_exp_t se;
    cm_exp_t   ce;
    int        bcnt;
    logic      busy_prev;
    bcnt = 0;
    busy_prev = 1'b0;
    forever begin
      @(negedge dclk);
      if (rd_cap) begin
        if (rd_q.size() == 0) check("rd_queue_underflow", 0, 1);
        else begin
          re = rd_q.pop_front();
          check({re.name, ".letter"}, int'(rd_letter), int'(re.letter));
          check({re.name, ".filled"}, int'(rd_filled), int'(re.filled));
          check({re.name, ".status"}, int'(rd_status), int'(re.status));
        end
      end
      if (snap_issue) begin
        if (sn_q.size() == 0) check("snap_queue_underflow", 0, 1);
        else begin
          se = sn_q.pop_front();
          check({se.name, ".cur_row"}, int'(cur_row), se.row);
          check({se.name, ".cur_col"}, int'(cur_col), se.col);
          check({se.name, ".game_state"}, int'(game_state), se.gs);
          check({se.name, ".key_ready"}, int'(key_ready), se.kr);
          check({se.name, ".busy"}, int'(busy), 0);
        end
      end
      if (busy) bcnt++;
      if (busy_prev && !busy) begin
        if (cm_q.size() == 0) check("commit_queue_underflow", 0, 1);
        else begin
          ce = cm_q.pop_front();
          check({ce.name, ".busy_cycles"}, bcnt, ce.cycles);
          check({ce.name, ".cur_row"}, int'(cur_row), ce.row);
          check({ce.name, ".cur_col"}, int'(cur_col), ce.col);
          check({ce.name, ".game_state"}, int'(game_state), ce.gs);
          check({ce.name, ".key_ready"}, int'(key_ready), ce.kr);
        end
        bcnt = 0;
      end
      busy_prev = busy;
    end
  end

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cm_exp_t ce;
    model_clear('0);
    repeat (3) tick();
    clr = 1'b0;
    snap("reset");
    do_read(0, 0, "reset_cell00");

    // Straight win
    start_game(w5("CRANE"));
    type_word(w5("CRANE"));
    send_key(KeyEnter, 5'd0);
    send_key(KeyLetter, 5'd3);
    snap("won_keys_ignored");

    // Duplicate handling
    start_game(w5("APPLE"));
    type_word(w5("PAPER"));
    send_key(KeyEnter, 5'd0);
    snap("apple_paper");

    start_game(w5("CRANE"));
    type_word(w5("EERIE"));
    send_key(KeyEnter, 5'd0);

    // Editing boundaries
    start_game(w5("CRANE"));
    send_key(KeyBackspace, 5'd0);
    snap("bksp_at_col0");
    send_key(KeyLetter, 5'd1);
    send_key(KeyLetter, 5'd2);
    send_key(KeyLetter, 5'd3);
    send_key(KeyLetter, 5'd4);
    send_key(KeyEnter, 5'd0);
    snap("enter_at_col4");
    send_key(KeyLetter, 5'd27);
    send_key(KeyReserved, 5'd7);
    snap("bad_code_ignored");
    send_key(KeyLetter, 5'd5);
    send_key(KeyLetter, 5'd6);
    snap("sixth_letter_dropped");
    read_row(0);
    send_key(KeyBackspace, 5'd0);
    do_read(0, 4, "after_bksp");
    do_read(6, 0, "oob_row");
    do_read(0, 5, "oob_col");
    do_read(7, 7, "oob_both");

    // Six misses
    for (int g = 0; g < 6; g++) begin
      type_word(w5("BLIMP"));
      send_key(KeyEnter, 5'd0);
    end
    snap("lost");
    send_key(KeyLetter, 5'd1);
    send_key(KeyEnter, 5'd0);
    snap("lost_keys_ignored");

    // new_game during the second scoring pass
    start_game(w5("APPLE"));
    type_word(w5("PAPER"));
    key_valid = 1'b1; key_type = KeyEnter; key_code = 5'd0;
    tick();
    key_valid = 1'b0;
    repeat (7) tick();
    model_clear(w5("LEMON"));
    ce.name = "abort"; ce.cycles = 8; ce.row = 0; ce.col = 0; ce.gs = 0; ce.kr = 1;
    cm_q.push_back(ce);
    target_word = w5("LEMON");
    new_game = 1'b1;
    tick();
    new_game = 1'b0;
    snap("after_abort");
    read_row(0);
    type_word(w5("MELON"));
    send_key(KeyEnter, 5'd0);

    // Random games over a small alphabet to force repeated letters
    for (int g = 0; g < 6; g++) begin
      logic [24:0] tw;
      int r;
      for (int i = 0; i < 5; i++) tw[i*5 +: 5] = 5'($urandom_range(0, 5));
      start_game(tw);
      for (int k = 0; k < 200 && m_gs == 0; k++) begin
        r = $urandom_range(0, 99);
        if (r < 25 && m_col < 5) send_key(KeyLetter, m_tgt[m_col]);
        else if (r < 65) send_key(KeyLetter, 5'($urandom_range(0, 5)));
        else if (r < 70) send_key(KeyLetter, 5'($urandom_range(26, 31)));
        else if (r < 80) send_key(KeyBackspace, 5'd0);
        else if (r < 95) send_key(KeyEnter, 5'd0);
        else send_key(KeyReserved, 5'($urandom_range(0, 31)));
      end
      snap("random_game_end");
      do_read($urandom_range(0, 7), $urandom_range(0, 7), "random_read");
    end

    repeat (3) tick();
    check("rd_queue_left", rd_q.size(), 0);
    check("snap_queue_left", sn_q.size(), 0);
    check("commit_queue_left", cm_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
